latch_wr_arbiter: RTL

Round-robin write arbiter and sequencer for a bank of level-sensitive D latches shared by several requesters. It grants one requester at a time and drives the shared latch data bus and the per-latch enables. Each write runs as a fixed SETUP → OPEN → HOLD sequence, so data is stable before a latch opens and after it closes. It sits between the requesters and the latch bank; the latches themselves stay pure `en ? d_in : q` cells.

---
 rtl/latch_wr_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/latch_wr_arbiter.sv
// latch_wr_arbiter
//   Round-robin write arbiter and sequencer for a bank of level-sensitive
//   D latches shared by NREQ requesters. Each granted write runs as a
//   SETUP -> OPEN -> HOLD sequence, so lat_d is stable before the selected
//   latch opens and stays stable after it closes.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   req       per-requester write request, held high until ack
//   req_addr  flattened addresses, requester i at [i*AW +: AW]
//   req_data  flattened data, requester i at [i*DW +: DW]
//   gnt       one-hot grant, held for the whole transaction
//   ack       one-hot single-cycle completion pulse (during HOLD)
//   lat_en    per-latch enable, at most one bit high
//   lat_d     shared latch data bus
//   busy      high whenever the sequencer is not idle
module latch_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int OPEN_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [(2**AW)-1:0]   lat_en,
    output logic [DW-1:0]        lat_d,
    output logic                 busy
);

    localparam int          DEPTH  = 2**AW;
    localparam int          WW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW     = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
    localparam int unsigned NREQ_U = NREQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     win_q, win_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DEPTH-1:0]  lat_en_q, lat_en_d;
    logic [DW-1:0]     lat_d_q, lat_d_d;
    logic              busy_q, busy_d;

    // Per-requester views of the flattened address/data buses
    logic [AW-1:0]     addr_arr [NREQ];
    logic [DW-1:0]     data_arr [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Round-robin search: first requesting index at or above ptr, with wrap
    logic          found;
    logic [WW-1:0] pick;
    logic [WW-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            idx = WW'((32'(ptr_q) + i) % NREQ_U);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state and registered-output logic. lat_d_q doubles as the
    // captured write data: it is loaded only at grant.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        addr_d   = addr_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        lat_en_d = '0;
        lat_d_d  = lat_d_q;
        busy_d   = busy_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    addr_d  = addr_arr[pick];
                    lat_d_d = data_arr[pick];
                    gnt_d   = NREQ'(1) << pick;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d    = '0;
                lat_en_d = DEPTH'(1) << addr_q;
                state_d  = S_OPEN;
            end
            S_OPEN: begin
                if (cnt_q == CW'(OPEN_CYC - 1)) begin
                    ack_d   = NREQ'(1) << win_q;
                    state_d = S_HOLD;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    lat_en_d = DEPTH'(1) << addr_q;
                end
            end
            S_HOLD: begin
                ptr_d   = (win_q == WW'(NREQ - 1)) ? '0 : win_q + WW'(1);
                cnt_d   = '0;
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Asynchronous reset drops lat_en immediately so no latch is left open
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            addr_q   <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            lat_en_q <= '0;
            lat_d_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            lat_en_q <= lat_en_d;
            lat_d_q  <= lat_d_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign lat_en = lat_en_q;
    assign lat_d  = lat_d_q;
    assign busy   = busy_q;

endmodule
